// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: ROB tag/value widths, the CDB broadcast record and FU indices.
// The record's fu_id field is sized for the largest supported arbiter (8 FUs).
package tomasulo_pkg;

    localparam int ROB_TAG_W   = 5;
    localparam int XLEN        = 32;
    localparam int FU_ID_MAX_W = 3;

    typedef enum logic [1:0] {
        FU_ALU,
        FU_MUL,
        FU_LSU,
        FU_BRU
    } fu_id_e;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_W-1:0]   tag;
        logic [XLEN-1:0]        data;
        logic [FU_ID_MAX_W-1:0] fu_id;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational rotating-priority picker: first set request at or after ptr, modulo N.
module rr_select
    import tomasulo_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Candidate index carries one spare bit so ptr+k cannot overflow before the wrap.
    always_comb begin
        logic        found;
        logic [IW:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[IW-1:0]]   = 1'b1;
                idx                   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: grants one FU result per cycle, broadcasts it a cycle later.
// Optional broadcast/conflict counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int DATA_W = XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_req,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    output logic [NUM_FU-1:0]          fu_grant,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_FU)-1:0]  cdb_fu_id
`ifdef CDB_ARB_STATS_EN
   ,output logic [31:0]                stat_bcast,
    output logic [31:0]                stat_conflict
`endif
);

    localparam int IW = $clog2(NUM_FU);

    logic [NUM_FU-1:0] selGrant;
    logic [IW-1:0]     selIdx;
    logic [TAG_W-1:0]  selTag;
    logic [DATA_W-1:0] selData;
    logic              grantValid;
    logic [IW-1:0]     rrPtr_q, rrPtr_d;
    cdb_bus_t          cdb_q, cdb_d;

    rr_select #(.N(NUM_FU), .IW(IW)) u_select (
        .req   (fu_req),
        .ptr   (rrPtr_q),
        .grant (selGrant),
        .idx   (selIdx)
    );

    assign fu_grant   = (rst || flush) ? '0 : selGrant;
    assign grantValid = |fu_grant;

    // One-hot mux keeps every slice index a loop constant.
    always_comb begin
        selTag  = '0;
        selData = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (selGrant[i]) begin
                selTag  = fu_tag[i*TAG_W +: TAG_W];
                selData = fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rrPtr_d     = rrPtr_q;
        cdb_d       = cdb_q;
        cdb_d.valid = grantValid;
        if (grantValid) begin
            rrPtr_d     = (selIdx == IW'(NUM_FU-1)) ? '0 : selIdx + 1'b1;
            cdb_d.tag   = ROB_TAG_W'(selTag);
            cdb_d.data  = XLEN'(selData);
            cdb_d.fu_id = FU_ID_MAX_W'(selIdx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q <= '0;
            cdb_q   <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
            cdb_q   <= cdb_d;
        end
    end

    assign cdb_valid = cdb_q.valid;
    assign cdb_tag   = TAG_W'(cdb_q.tag);
    assign cdb_data  = DATA_W'(cdb_q.data);
    assign cdb_fu_id = cdb_q.fu_id[IW-1:0];

`ifdef CDB_ARB_STATS_EN
    logic [31:0] statBcast_q, statConflict_q;
    logic        conflict;

    assign conflict = !flush && ($countones(fu_req) >= 2);

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            statBcast_q    <= '0;
            statConflict_q <= '0;
        end else begin
            if (grantValid && (statBcast_q != '1)) begin
                statBcast_q <= statBcast_q + 32'd1;
            end
            if (conflict && (statConflict_q != '1)) begin
                statConflict_q <= statConflict_q + 32'd1;
            end
        end
    end

    assign stat_bcast    = statBcast_q;
    assign stat_conflict = statConflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus a hand-written fairness sequence.
// Stats counters are also checked when CDB_ARB_STATS_EN is defined.
module tb_cdb_arbiter;

    localparam logic [31:0] D0 = 32'h0000_1111;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h3333_CAFE;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   fuReq;
    logic [19:0]  fuTag;
    logic [127:0] fuData;
    logic [3:0]   fuGrant;
    logic         cdbValid;
    logic [4:0]   cdbTag;
    logic [31:0]  cdbData;
    logic [1:0]   cdbFuId;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]  statBcast;
    logic [31:0]  statConflict;
`endif

    logic [4:0]   tagArr [4];
    logic [31:0]  dataArr[4];
    int           numChecks = 0;
    int           numFails  = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [3:0]  req;
        logic [3:0]  expGrant;
        logic        chkCdb;
        logic        expValid;
        logic [4:0]  expTag;
        logic [31:0] expData;
        logic [1:0]  expId;
        logic        chkStat;
        logic [31:0] expBcast;
        logic [31:0] expConf;
    } vec_t;

    vec_t vecs[25];

    cdb_arbiter #(.NUM_FU(4), .TAG_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_req    (fuReq),
        .fu_tag    (fuTag),
        .fu_data   (fuData),
        .fu_grant  (fuGrant),
        .cdb_valid (cdbValid),
        .cdb_tag   (cdbTag),
        .cdb_data  (cdbData),
        .cdb_fu_id (cdbFuId)
`ifdef CDB_ARB_STATS_EN
       ,.stat_bcast    (statBcast),
        .stat_conflict (statConflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic r, logic f, logic [3:0] req, logic [3:0] g, logic chk,
                                logic v, logic [4:0] t, logic [31:0] d, logic [1:0] id);
        vec_t x;
        x.rst = r;  x.flush = f;  x.req = req;  x.expGrant = g;
        x.chkCdb = chk;  x.expValid = v;  x.expTag = t;  x.expData = d;  x.expId = id;
        x.chkStat = 1'b0;  x.expBcast = '0;  x.expConf = '0;
        return x;
    endfunction

    task automatic applyStimulus(input logic r, input logic f, input logic [3:0] req);
        @(negedge clk);
        rst   = r;
        flush = f;
        fuReq = req;
        for (int i = 0; i < 4; i++) begin
            fuTag[i*5 +: 5]    = tagArr[i];
            fuData[i*32 +: 32] = dataArr[i];
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] prevReq;
        logic [3:0] prevGrant;
        logic       prevRst;
        logic [3:0] seqGrant[8];
        logic [4:0] seqTag[8];
        logic [1:0] seqId[8];

        rst = 1'b1;  flush = 1'b0;  fuReq = '0;  fuTag = '0;  fuData = '0;
        tagArr[0] = 5'd3;   dataArr[0] = D0;
        tagArr[1] = 5'd12;  dataArr[1] = D1;
        tagArr[2] = 5'd7;   dataArr[2] = D2;
        tagArr[3] = 5'd20;  dataArr[3] = D3;

        //                rst flush req      grant    chk v  tag    data          id
        vecs[0]  = mk(1, 0, 4'b1111, 4'b0000, 0, 0, 5'd0,  32'h0, 2'd0);
        vecs[1]  = mk(1, 0, 4'b1111, 4'b0000, 1, 0, 5'd0,  32'h0, 2'd0);
        vecs[2]  = mk(0, 0, 4'b0000, 4'b0000, 1, 0, 5'd0,  32'h0, 2'd0);
        vecs[3]  = mk(0, 0, 4'b0100, 4'b0100, 1, 0, 5'd0,  32'h0, 2'd0);
        vecs[4]  = mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd7,  D2,    2'd2);
        vecs[5]  = mk(1, 0, 4'b0000, 4'b0000, 1, 0, 5'd7,  D2,    2'd2);
        vecs[6]  = mk(0, 0, 4'b1111, 4'b0001, 1, 0, 5'd0,  32'h0, 2'd0);
        vecs[7]  = mk(0, 0, 4'b1110, 4'b0010, 1, 1, 5'd3,  D0,    2'd0);
        vecs[8]  = mk(0, 0, 4'b1100, 4'b0100, 1, 1, 5'd12, D1,    2'd1);
        vecs[9]  = mk(0, 0, 4'b1000, 4'b1000, 1, 1, 5'd7,  D2,    2'd2);
        vecs[10] = mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd20, D3,    2'd3);
        vecs[11] = mk(0, 0, 4'b0100, 4'b0100, 1, 0, 5'd20, D3,    2'd3);
        vecs[12] = mk(0, 0, 4'b1001, 4'b1000, 1, 1, 5'd7,  D2,    2'd2);
        vecs[13] = mk(0, 0, 4'b0001, 4'b0001, 1, 1, 5'd20, D3,    2'd3);
        vecs[14] = mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd3,  D0,    2'd0);
        vecs[15] = mk(0, 1, 4'b0011, 4'b0000, 1, 0, 5'd3,  D0,    2'd0);
        vecs[16] = mk(0, 0, 4'b0011, 4'b0010, 1, 0, 5'd3,  D0,    2'd0);
        vecs[17] = mk(0, 0, 4'b0001, 4'b0001, 1, 1, 5'd12, D1,    2'd1);
        vecs[18] = mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd3,  D0,    2'd0);
        vecs[19] = mk(0, 0, 4'b0100, 4'b0100, 1, 0, 5'd3,  D0,    2'd0);
        vecs[20] = mk(0, 1, 4'b0000, 4'b0000, 1, 1, 5'd7,  D2,    2'd2);
        vecs[21] = mk(0, 0, 4'b1000, 4'b1000, 1, 0, 5'd7,  D2,    2'd2);
        vecs[22] = mk(1, 0, 4'b1111, 4'b0000, 1, 1, 5'd20, D3,    2'd3);
        vecs[23] = mk(0, 0, 4'b0010, 4'b0010, 1, 0, 5'd0,  32'h0, 2'd0);
        vecs[24] = mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd12, D1,    2'd1);
        vecs[2].chkStat  = 1'b1;
        vecs[10].chkStat = 1'b1;  vecs[10].expBcast = 32'd4;  vecs[10].expConf = 32'd3;

        prevReq = '0;  prevGrant = '0;  prevRst = 1'b1;
        for (int r = 0; r < 25; r++) begin
            applyStimulus(vecs[r].rst, vecs[r].flush, vecs[r].req);
            checkOutput($sformatf("row%0d grant", r), 32'(fuGrant), 32'(vecs[r].expGrant));
            if (vecs[r].chkCdb) begin
                checkOutput($sformatf("row%0d cdb_valid", r), 32'(cdbValid), 32'(vecs[r].expValid));
                checkOutput($sformatf("row%0d cdb_tag", r),   32'(cdbTag),   32'(vecs[r].expTag));
                checkOutput($sformatf("row%0d cdb_data", r),  cdbData,       vecs[r].expData);
                checkOutput($sformatf("row%0d cdb_fu_id", r), 32'(cdbFuId),  32'(vecs[r].expId));
            end
            if (!prevRst) begin
                checkOutput($sformatf("row%0d protocol drop", r),
                            32'(prevReq & ~prevGrant & ~vecs[r].req), 32'd0);
            end
`ifdef CDB_ARB_STATS_EN
            if (vecs[r].chkStat) begin
                checkOutput($sformatf("row%0d stat_bcast", r),    statBcast,    vecs[r].expBcast);
                checkOutput($sformatf("row%0d stat_conflict", r), statConflict, vecs[r].expConf);
            end
`endif
            prevReq   = vecs[r].req;
            prevGrant = fuGrant;
            prevRst   = vecs[r].rst;
        end

        // Fairness: all four FUs keep requesting, each presents a fresh tag (+8) after its grant.
        seqGrant = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        seqTag   = '{5'd7, 5'd20, 5'd3, 5'd12, 5'd15, 5'd28, 5'd11, 5'd20};
        seqId    = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            checkOutput($sformatf("fair%0d grant", k), 32'(fuGrant), 32'(seqGrant[k]));
            if (k > 0) begin
                checkOutput($sformatf("fair%0d cdb_valid", k), 32'(cdbValid), 32'd1);
                checkOutput($sformatf("fair%0d cdb_tag", k),   32'(cdbTag),   32'(seqTag[k-1]));
                checkOutput($sformatf("fair%0d cdb_fu_id", k), 32'(cdbFuId),  32'(seqId[k-1]));
            end
            for (int i = 0; i < 4; i++) begin
                if (seqGrant[k][i]) tagArr[i] = tagArr[i] + 5'd8;
            end
        end
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("fair_end grant",     32'(fuGrant),  32'd0);
        checkOutput("fair_end cdb_valid", 32'(cdbValid), 32'd1);
        checkOutput("fair_end cdb_tag",   32'(cdbTag),   32'(seqTag[7]));
        checkOutput("fair_end cdb_fu_id", 32'(cdbFuId),  32'(seqId[7]));
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("idle cdb_valid", 32'(cdbValid), 32'd0);
        checkOutput("idle cdb_tag",   32'(cdbTag),   32'(seqTag[7]));

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
